// File: rtl/rgmii_tx_if_if.sv
// GMII transmit bus between a MAC (master) and the RGMII transmit adapter (slave).
// The adapter paces the MAC through gmii_clk_en.
interface rgmii_tx_if_if;
   logic [7:0] gmii_txd;
   logic       gmii_tx_en;
   logic       gmii_tx_er;
   logic       gmii_clk_en;

   modport master (output gmii_txd, gmii_tx_en, gmii_tx_er, input gmii_clk_en);
   modport slave  (input gmii_txd, gmii_tx_en, gmii_tx_er, output gmii_clk_en);
endinterface

// File: rtl/rgmii_tx_if.sv
// RGMII transmit adapter: turns the 8-bit GMII stream into registered rising/falling
// oddr input pairs. The adapter sends DDR at 1000 and one nibble per divided TXC period at 10/100.
module rgmii_tx_if (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    speed,
   rgmii_tx_if_if.slave  gmii,
   output logic [3:0]    txd_1,
   output logic [3:0]    txd_2,
   output logic          ctl_1,
   output logic          ctl_2,
   output logic          txc_1,
   output logic          txc_2
);
   typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_t;

   logic [1:0] speed_q;
   logic       run_q;
   logic [5:0] cnt_q, cnt_d;
   phase_t     phase_q, phase_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] txd_1_q, txd_1_d, txd_2_q, txd_2_d;
   logic       ctl_1_q, ctl_1_d, ctl_2_q, ctl_2_d;
   logic       txc_1_q, txc_1_d, txc_2_q, txc_2_d;
   logic       clk_en_q, clk_en_d;

   logic [5:0] last_cnt;
   logic       is_fast;
   logic       restart;

   always_comb begin
      last_cnt = 6'd0;
      case (speed)
         2'b01:   last_cnt = 6'd4;
         2'b00:   last_cnt = 6'd49;
         default: last_cnt = 6'd0;
      endcase
   end

   assign is_fast = speed[1];
   // The first cycle out of reset is treated like a speed change, so every mode starts from cnt=0.
   assign restart = !run_q || (speed != speed_q);

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      hold_d  = hold_q;
      txd_1_d = txd_1_q;
      txd_2_d = txd_2_q;
      ctl_1_d = ctl_1_q;
      ctl_2_d = ctl_2_q;
      txc_1_d = 1'b0;
      txc_2_d = 1'b0;

      if (restart) begin
         cnt_d   = 6'd0;
         phase_d = PH_LO;
         hold_d  = 8'd0;
         txd_1_d = 4'd0;
         txd_2_d = 4'd0;
         ctl_1_d = 1'b0;
         ctl_2_d = 1'b0;
      end else if (is_fast) begin
         cnt_d   = 6'd0;
         phase_d = PH_LO;
         txd_1_d = gmii.gmii_txd[3:0];
         txd_2_d = gmii.gmii_txd[7:4];
         ctl_1_d = gmii.gmii_tx_en;
         ctl_2_d = gmii.gmii_tx_en ^ gmii.gmii_tx_er;
      end else if (cnt_q == last_cnt) begin
         cnt_d = 6'd0;
         if (phase_q == PH_HI) begin
            hold_d  = gmii.gmii_txd;
            phase_d = PH_LO;
            txd_1_d = gmii.gmii_txd[3:0];
            txd_2_d = gmii.gmii_txd[3:0];
            ctl_1_d = gmii.gmii_tx_en;
            ctl_2_d = gmii.gmii_tx_en ^ gmii.gmii_tx_er;
         end else begin
            phase_d = PH_HI;
            txd_1_d = hold_q[7:4];
            txd_2_d = hold_q[7:4];
         end
      end else begin
         cnt_d = cnt_q + 6'd1;
      end

      // TXC is decoded from the next count so it rises together with the data change at cnt 0.
      if (is_fast) begin
         txc_1_d = 1'b1;
         txc_2_d = 1'b0;
      end else if (speed == 2'b01) begin
         txc_1_d = (cnt_d < 6'd3);
         txc_2_d = (cnt_d < 6'd2);
      end else begin
         txc_1_d = (cnt_d < 6'd25);
         txc_2_d = txc_1_d;
      end

      clk_en_d = is_fast || ((cnt_d == last_cnt) && (phase_d == PH_HI));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         speed_q  <= 2'b00;
         run_q    <= 1'b0;
         cnt_q    <= 6'd0;
         phase_q  <= PH_LO;
         hold_q   <= 8'd0;
         txd_1_q  <= 4'd0;
         txd_2_q  <= 4'd0;
         ctl_1_q  <= 1'b0;
         ctl_2_q  <= 1'b0;
         txc_1_q  <= 1'b0;
         txc_2_q  <= 1'b0;
         clk_en_q <= 1'b0;
      end else begin
         speed_q  <= speed;
         run_q    <= 1'b1;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         hold_q   <= hold_d;
         txd_1_q  <= txd_1_d;
         txd_2_q  <= txd_2_d;
         ctl_1_q  <= ctl_1_d;
         ctl_2_q  <= ctl_2_d;
         txc_1_q  <= txc_1_d;
         txc_2_q  <= txc_2_d;
         clk_en_q <= clk_en_d;
      end
   end

   assign gmii.gmii_clk_en = clk_en_q;
   assign txd_1 = txd_1_q;
   assign txd_2 = txd_2_q;
   assign ctl_1 = ctl_1_q;
   assign ctl_2 = ctl_2_q;
   assign txc_1 = txc_1_q;
   assign txc_2 = txc_2_q;
endmodule

// File: tb/tb_rgmii_tx_if.sv
// Directed bench for rgmii_tx_if: 1000-mode vector table plus cycle-accurate 10/100 sequences,
// a speed change and a mid-frame reset.
module tb_rgmii_tx_if;
   logic       clk;
   logic       rst;
   logic [1:0] speed;
   logic [3:0] txd_1, txd_2;
   logic       ctl_1, ctl_2, txc_1, txc_2;

   int checks = 0;
   int errors = 0;

   rgmii_tx_if_if gmii_bus ();

   rgmii_tx_if dut (
      .clk   (clk),
      .rst   (rst),
      .speed (speed),
      .gmii  (gmii_bus.slave),
      .txd_1 (txd_1),
      .txd_2 (txd_2),
      .ctl_1 (ctl_1),
      .ctl_2 (ctl_2),
      .txc_1 (txc_1),
      .txc_2 (txc_2)
   );

   initial clk = 1'b0;
   always #4 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       en;
      logic       er;
      logic [3:0] t1;
      logic [3:0] t2;
      logic       c1;
      logic       c2;
   } vec_t;

   vec_t vecs[5];

   // Packed view of all outputs: {clk_en, txd_1, txd_2, ctl_1, ctl_2, txc_1, txc_2}
   function automatic logic [12:0] pack();
      return {gmii_bus.gmii_clk_en, txd_1, txd_2, ctl_1, ctl_2, txc_1, txc_2};
   endfunction

   function automatic logic [12:0] mk(input logic ce, input logic [3:0] t1, input logic [3:0] t2,
                                      input logic c1, input logic c2, input logic k1, input logic k2);
      return {ce, t1, t2, c1, c2, k1, k2};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] d, input logic en, input logic er);
      gmii_bus.gmii_txd   = d;
      gmii_bus.gmii_tx_en = en;
      gmii_bus.gmii_tx_er = er;
   endtask

   // Leaves the bench in the cycle just before the first edge with rst low.
   task automatic do_reset(input logic [1:0] s);
      rst   = 1'b1;
      speed = s;
      drive(8'h00, 1'b0, 1'b0);
      repeat (3) tick();
      chk("reset", pack(), 13'd0);
      rst = 1'b0;
   endtask

   // Runs ncyc cycles of a 10/100 mode from a fresh start (cycle 0 = first cycle after restart).
   // b0 is the first byte {er,en,data}; b1 is used for every later byte.
   task automatic run_slow(input int p, input int ncyc, input logic [9:0] b0, input logic [9:0] b1);
      logic [9:0] b;
      logic [3:0] nib;
      logic       ce, k1, k2, c1, c2;
      int         m, k, w;
      for (int c = 0; c < ncyc; c++) begin
         tick();
         ce = ((c % (2 * p)) == (2 * p - 1));
         if (p == 5) begin
            m  = c % 5;
            k1 = (m < 3);
            k2 = (m < 2);
         end else begin
            m  = c % 50;
            k1 = (m < 25);
            k2 = k1;
         end
         if (c < 2 * p) begin
            nib = 4'd0;
            c1  = 1'b0;
            c2  = 1'b0;
         end else begin
            k   = (c - 2 * p) / (2 * p);
            b   = (k == 0) ? b0 : b1;
            w   = (c - 2 * p) % (2 * p);
            nib = (w < p) ? b[3:0] : b[7:4];
            c1  = b[8];
            c2  = b[8] ^ b[9];
         end
         chk($sformatf("slow_p%0d_c%0d", p, c), pack(), mk(ce, nib, nib, c1, c2, k1, k2));
         if (ce) begin
            k = (c + 1) / (2 * p) - 1;
            b = (k == 0) ? b0 : b1;
            drive(b[7:0], b[8], b[9]);
            $display("P=%0d cycle %0d: byte %h en=%b er=%b presented", p, c, b[7:0], b[8], b[9]);
         end else begin
            drive(8'hC3, 1'b0, 1'b0);
         end
      end
   endtask

   initial begin
      vecs[0] = '{d: 8'hA5, en: 1'b1, er: 1'b0, t1: 4'h5, t2: 4'hA, c1: 1'b1, c2: 1'b1};
      vecs[1] = '{d: 8'h3C, en: 1'b1, er: 1'b0, t1: 4'hC, t2: 4'h3, c1: 1'b1, c2: 1'b1};
      vecs[2] = '{d: 8'h0F, en: 1'b0, er: 1'b1, t1: 4'hF, t2: 4'h0, c1: 1'b0, c2: 1'b1};
      vecs[3] = '{d: 8'h12, en: 1'b0, er: 1'b0, t1: 4'h2, t2: 4'h1, c1: 1'b0, c2: 1'b0};
      vecs[4] = '{d: 8'hFF, en: 1'b1, er: 1'b1, t1: 4'hF, t2: 4'hF, c1: 1'b1, c2: 1'b0};

      // 1000 mode: clk_en high from the first cycle, one clock latency.
      do_reset(2'b10);
      tick();
      chk("g1000_first", pack(), mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
      for (int i = 0; i < 5; i++) begin
         drive(vecs[i].d, vecs[i].en, vecs[i].er);
         tick();
         chk($sformatf("g1000_vec%0d", i), pack(),
             mk(1'b1, vecs[i].t1, vecs[i].t2, vecs[i].c1, vecs[i].c2, 1'b1, 1'b0));
         $display("1000 vec %0d: txd=%h en=%b er=%b -> txd_1=%h txd_2=%h ctl=%b%b",
                  i, vecs[i].d, vecs[i].en, vecs[i].er, txd_1, txd_2, ctl_1, ctl_2);
      end

      // speed 2'b11 behaves as 1000 after the restart cycle.
      speed = 2'b11;
      drive(8'h55, 1'b1, 1'b0);
      tick();
      chk("spd11_restart", pack(), mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
      drive(8'h96, 1'b1, 1'b0);
      tick();
      chk("spd11_byte", pack(), mk(1'b1, 4'h6, 4'h9, 1'b1, 1'b1, 1'b1, 1'b0));
      $display("speed 11: byte 96 -> txd_1=%h txd_2=%h", txd_1, txd_2);

      // 100 mode from reset: first clk_en at cycle 9, bytes 7E then 5A.
      do_reset(2'b01);
      run_slow(5, 40, {1'b0, 1'b1, 8'h7E}, {1'b0, 1'b1, 8'h5A});

      // 100 -> 1000 while the high nibble of 7E is on the wire.
      do_reset(2'b01);
      run_slow(5, 17, {1'b0, 1'b1, 8'h7E}, {1'b0, 1'b1, 8'h5A});
      speed = 2'b10;
      drive(8'h5A, 1'b1, 1'b0);
      tick();
      chk("chg_idle", pack(), mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
      drive(8'hB4, 1'b1, 1'b0);
      tick();
      chk("chg_first", pack(), mk(1'b1, 4'h4, 4'hB, 1'b1, 1'b1, 1'b1, 1'b0));
      $display("100->1000: byte B4 -> txd_1=%h txd_2=%h", txd_1, txd_2);

      // 10 mode: byte 42 with en=1 er=1, then 81 with en=1 er=0 partially.
      do_reset(2'b00);
      run_slow(50, 230, {1'b1, 1'b1, 8'h42}, {1'b0, 1'b1, 8'h81});

      // Reset pulse mid-frame, then a fresh 10 mode start.
      rst = 1'b1;
      tick();
      chk("rst_midframe", pack(), 13'd0);
      $display("10 mode: rst pulsed mid-frame, outputs=%h", pack());
      rst = 1'b0;
      run_slow(50, 100, {1'b0, 1'b1, 8'h11}, {1'b0, 1'b1, 8'h11});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rgmii_tx_if.md
Name: rgmii_tx_if

Overview:
- Transmit-side RGMII adapter: converts the MAC's 8-bit GMII transmit stream into registered rising-edge and falling-edge output pairs for the generic oddr cells driving TXD[3:0], TX_CTL and TXC.
- Runs from the 125 MHz MAC transmit clock.
- 1000 Mb/s mode: both nibbles of a byte are sent per TXC cycle.
- 10/100 Mb/s mode: divides the clock to 2.5/25 MHz TXC, sends one nibble per TXC cycle (SDR), and paces the MAC with a clock enable.

Parameters:
- None.

Ports:
- clk  input  1  125 MHz transmit clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- speed  input  2  2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 treated as 1000.
- gmii_txd  input  8  transmit byte; sampled only when gmii_clk_en=1.
- gmii_tx_en  input  1  transmit enable; sampled with gmii_txd.
- gmii_tx_er  input  1  transmit error; sampled with gmii_txd.
- gmii_clk_en  output  1  MAC must present a new byte in every cycle this is high.
- txd_1  output  4  TXD value for the rising half (oddr d1).
- txd_2  output  4  TXD value for the falling half (oddr d2).
- ctl_1  output  1  TX_CTL value for the rising half.
- ctl_2  output  1  TX_CTL value for the falling half.
- txc_1  output  1  TXC value for the rising half.
- txc_2  output  1  TXC value for the falling half.

Behaviour:
- Reset: every output 0; divider cnt=0; nibble phase=0; byte hold register and speed_reg cleared to 0.
- All outputs are registered.
- Period P: 1 for 1000, 5 for 100, 50 for 10.
- cnt counts 0..P-1 and wraps to 0.
- speed_reg is updated every cycle. If speed differs from speed_reg: cnt<=0, phase<=0, hold<=0, and outputs go to idle (all txd/ctl=0) for that cycle. This covers mid-frame changes; the partial byte is discarded. The MAC must only change speed while gmii_tx_en=0.

1000 mode:
- gmii_clk_en=1 every cycle after reset release, including the first cycle.
- One cycle after sampling: txd_1=gmii_txd[3:0], txd_2=gmii_txd[7:4], ctl_1=tx_en, ctl_2=tx_en^tx_er.
- txc_1=1, txc_2=0 constantly.
- Latency: 1 clk.

100 mode TXC pattern (by cnt, shown as txc_1,txc_2), 50% duty:
- cnt 0 and 1: 1,1.
- cnt 2: 1,0.
- cnt 3 and 4: 0,0.

10 mode TXC pattern:
- cnt 0..24: 1,1.
- cnt 25..49: 0,0.

10/100 data path:
- gmii_clk_en=1 exactly for one cycle when cnt==P-1 and phase==1; 0 otherwise.
- At that cycle the byte, en and er are captured into hold. The clock edge ending that cycle also sets cnt=0, phase=0, txd_1=txd_2=gmii_txd[3:0], ctl_1=ctl_2=... see next bullet.
- ctl_1=en and ctl_2=en^er, applied to both nibbles of the byte.
- At cnt wrap with phase==0: phase<=1, txd_1=txd_2=hold[7:4], ctl unchanged.
- Data is held stable for the whole TXC period (P cycles) and changes only at cnt==0, coincident with TXC rising. The TX clock skew is provided externally at the oddr/clock level.
- Latency from sampling to first nibble: 1 clk. Byte throughput: one per 2P cycles.
- First gmii_clk_en after reset release or a speed change: at cycle 2P-1. Outputs stay idle (0) until then; TXC still toggles.
- tx_en=0 bytes are sent as idle nibbles with ctl=0. Their txd value is passed through unmodified.
- rst asserted mid-frame: outputs are 0 on the next cycle regardless of phase.

Test Plan:
- 1000 mode, bytes 0xA5,0x3C with en=1,er=0 -> txd_1/txd_2 = 5/A, then C/3, one clk after each input; ctl_1=ctl_2=1; txc_1/2 = 1/0; gmii_clk_en constant 1.
- 100 mode after reset -> first gmii_clk_en at cycle 9, then every 10 cycles. Byte 0x7E -> txd=E for 5 cycles, then 7 for 5 cycles. TXC repeats (1,1),(1,1),(1,0),(0,0),(0,0).
- 10 mode, byte 0x42 with en=1,er=1 -> gmii_clk_en every 100 cycles; txd=2 for 50 cycles then 4 for 50; ctl_1=1, ctl_2=0; TXC high 25 cycles, low 25.
- Idle and error in 1000 mode: en=0,er=1 (carrier extend) -> ctl_1=0, ctl_2=1. en=0,er=0 -> ctl_1=ctl_2=0.
- Speed change 100->1000 mid-byte (phase=1) -> next cycle outputs idle and cnt/phase cleared; gmii_clk_en=1 from the following cycle; the partial byte is not resumed.
- rst pulsed for 1 cycle during a 10 mode frame -> all outputs 0 next cycle; first gmii_clk_en at cycle 99 after release.
